// File: rtl/data_mem_store_ctrl.sv
// data_mem_store_ctrl: sequences SB/SH/SW stores into a word-wide data memory, splitting misaligned stores.
// Optional macro STORE_SPLIT_EN builds the second beat; without it, stores that cross a word boundary fault.
module data_mem_store_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Store_Req,
  output logic                  Store_Ready,
  input  logic [2:0]            Lw_Sw_OP,
  input  logic [ADDR_WIDTH-1:0] Store_Addr,
  input  logic [31:0]           Register_In_B,
  output logic                  Mem_Wr_En,
  input  logic                  Mem_Ready,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [3:0]            Write_Ctrl,
  output logic [31:0]           Data_Mem_Write,
  output logic                  Store_Done,
  output logic                  Store_Err
);
  typedef enum logic [1:0] {IDLE, WR0, WR1, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0] rot_q, rot_d, rot_in;
  logic [7:0] full_q, full_d, full_in, base;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [1:0] off;
  logic op_ok, split_in, lim;
  logic [3:0] lanes;
  assign off = Store_Addr[1:0];
  always_comb begin
    base = Lw_Sw_OP == 3'd0 ? 8'h01 : Lw_Sw_OP == 3'd1 ? 8'h03 : 8'h0F;
    op_ok = Lw_Sw_OP <= 3'd2;
    full_in = base << off;
    split_in = |full_in[7:4];
    rot_in = off == 2'd0 ? Register_In_B :
             off == 2'd1 ? {Register_In_B[23:0], Register_In_B[31:24]} :
             off == 2'd2 ? {Register_In_B[15:0], Register_In_B[31:16]} :
                           {Register_In_B[7:0], Register_In_B[31:8]};
    lim = cnt_q == 8'(TIMEOUT_CYCLES - 1);
  end
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    rot_d = rot_q;
    full_d = full_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (Store_Req) begin
        waddr_d = {Store_Addr[ADDR_WIDTH-1:2], 2'b00};
        rot_d = rot_in;
        full_d = full_in;
        cnt_d = 8'd0;
`ifdef STORE_SPLIT_EN
        err_d = !op_ok;
`else
        err_d = !op_ok || split_in;
`endif
        state_d = err_d ? RESP : WR0;
      end
      WR0: if (Mem_Ready) begin
        cnt_d = 8'd0;
`ifdef STORE_SPLIT_EN
        state_d = |full_q[7:4] ? WR1 : RESP;
`else
        state_d = RESP;
`endif
      end else if (lim) begin
        err_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 8'd1;
`ifdef STORE_SPLIT_EN
      // beat0 stays committed even if beat1 times out
      WR1: if (Mem_Ready) state_d = RESP;
      else if (lim) begin
        err_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 8'd1;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      waddr_q <= '0;
      rot_q <= '0;
      full_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      rot_q <= rot_d;
      full_q <= full_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    lanes = state_q == WR0 ? full_q[3:0] : state_q == WR1 ? full_q[7:4] : 4'h0;
    Mem_Wr_En = state_q == WR0 || state_q == WR1;
    Mem_Addr = state_q == WR0 ? waddr_q : state_q == WR1 ? waddr_q + ADDR_WIDTH'(4) : '0;
    Write_Ctrl = lanes;
    Data_Mem_Write = rot_q & {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    Store_Ready = state_q == IDLE;
    Store_Done = state_q == RESP && !err_q;
    Store_Err = state_q == RESP && err_q;
  end
endmodule

// File: tb/tb_data_mem_store_ctrl.sv
// tb_data_mem_store_ctrl: scoreboard bench; a byte-level store model predicts beats and responses.
module tb_data_mem_store_ctrl;
  localparam int TO = 4;
  logic Clk = 0, Reset = 1, Store_Req = 0, Mem_Ready = 0;
  logic [2:0] Lw_Sw_OP = 0;
  logic [31:0] Store_Addr = 0, Register_In_B = 0;
  logic Store_Ready, Mem_Wr_En, Store_Done, Store_Err;
  logic [31:0] Mem_Addr, Data_Mem_Write;
  logic [3:0] Write_Ctrl;
  int n_tot = 0, n_pass = 0;
  typedef struct {logic [31:0] a; logic [3:0] wc; logic [31:0] d; bit to;} beat_t;
  beat_t bq[$];
  logic [1:0] rq[$];

  data_mem_store_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Store_Req(Store_Req), .Store_Ready(Store_Ready),
    .Lw_Sw_OP(Lw_Sw_OP), .Store_Addr(Store_Addr), .Register_In_B(Register_In_B),
    .Mem_Wr_En(Mem_Wr_En), .Mem_Ready(Mem_Ready), .Mem_Addr(Mem_Addr),
    .Write_Ctrl(Write_Ctrl), .Data_Mem_Write(Data_Mem_Write),
    .Store_Done(Store_Done), .Store_Err(Store_Err));

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic pb(input logic [31:0] a, input logic [3:0] wc, input logic [31:0] d, input bit to);
    beat_t b;
    b.a = a; b.wc = wc; b.d = d; b.to = to;
    bq.push_back(b);
  endtask

  task automatic pr(input bit done, input bit err);
    rq.push_back({done, err});
  endtask

  // Byte-by-byte view of a store: each byte lands at addr+k, grouped into the words it touches.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input int w0, input int w1);
    int sz, nw, lane, w;
    logic [31:0] wa[2], wd[2], ba;
    logic [3:0] wc[2];
    sz = op == 0 ? 1 : op == 1 ? 2 : op == 2 ? 4 : 0;
    if (sz == 0) begin pr(0, 1); return; end
    nw = 0;
    for (int k = 0; k < sz; k++) begin
      ba = addr + 32'(k);
      if (nw == 0 || (ba & ~32'h3) != wa[nw-1]) begin
        wa[nw] = ba & ~32'h3; wc[nw] = 0; wd[nw] = 0; nw++;
      end
      lane = int'(ba % 4);
      wc[nw-1][lane] = 1'b1;
      wd[nw-1][8*lane +: 8] = data[8*k +: 8];
    end
`ifndef STORE_SPLIT_EN
    if (nw > 1) begin pr(0, 1); return; end
`endif
    for (int i = 0; i < nw; i++) begin
      w = i == 0 ? w0 : w1;
      if (w >= TO) begin pb(wa[i], wc[i], wd[i], 1); pr(0, 1); return; end
      pb(wa[i], wc[i], wd[i], 0);
    end
    pr(1, 0);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input int w0, input int w1);
    int t, k, w;
    t = 0;
    while (Store_Ready !== 1'b1 && t < 20) begin @(posedge Clk); #1; t++; end
    if (Store_Ready !== 1'b1) chk("ready_wait", Store_Ready, 1);
    Store_Req = 1; Lw_Sw_OP = op; Store_Addr = addr; Register_In_B = data;
    Mem_Ready = 1'($urandom);
    @(posedge Clk); #1;
    Store_Req = 0; Mem_Ready = 0;
    k = 0;
    while (Mem_Wr_En === 1'b1 && k < 2) begin
      w = k == 0 ? w0 : w1;
      for (int i = 0; i < w && i < TO; i++) begin
        Mem_Ready = 0;
        Store_Req = 1'($urandom); Lw_Sw_OP = 3'($urandom);
        Store_Addr = $urandom; Register_In_B = $urandom;
        @(posedge Clk); #1;
      end
      if (w < TO) begin Mem_Ready = 1; @(posedge Clk); #1; Mem_Ready = 0; end
      k++;
    end
    Store_Req = 0;
    chk("resp_latency", {Store_Done | Store_Err, Store_Ready}, 2'b10);
    @(posedge Clk); #1;
    chk("ready_after_resp", Store_Ready, 1);
  endtask

  task automatic store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input int w0, input int w1);
    model(op, addr, data, w0, w1);
    drive(op, addr, data, w0, w1);
  endtask

  always @(negedge Clk) if (!Reset) begin
    if (Mem_Wr_En) begin
      if (bq.size() == 0) chk("unexpected_beat", Mem_Wr_En, 0);
      else begin
        chk("beat_addr", Mem_Addr, bq[0].a);
        chk("beat_wc", Write_Ctrl, bq[0].wc);
        chk("beat_data", Data_Mem_Write, bq[0].d);
        if (Mem_Ready) bq.delete(0);
      end
    end
    if (Store_Done || Store_Err) begin
      if (rq.size() == 0) chk("unexpected_resp", {Store_Done, Store_Err}, 0);
      else begin
        chk("resp", {Store_Done, Store_Err}, rq[0]);
        rq.delete(0);
      end
      if (bq.size() != 0 && bq[0].to) bq.delete(0);
      chk("leftover_beats", bq.size(), 0);
    end
  end

  initial begin
    #100000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0, w1;
    logic [2:0] op;
    logic [31:0] addr;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outputs", {Mem_Wr_En, Mem_Addr, Write_Ctrl, Data_Mem_Write, Store_Done, Store_Err, Store_Ready}, 71'h1);
    Reset = 0;
    @(posedge Clk); #1;
    Store_Req = 1; Lw_Sw_OP = 3'd2; Store_Addr = 32'h40; Register_In_B = 32'h12345678;
    @(posedge Clk); #1;
    Store_Req = 0; Mem_Ready = 0;
    chk("wr0_before_reset", Mem_Wr_En, 1);
    Reset = 1; #1;
    chk("mid_beat_reset", {Mem_Wr_En, Mem_Addr, Write_Ctrl, Data_Mem_Write, Store_Done, Store_Err, Store_Ready}, 71'h1);
    @(posedge Clk); #1;
    Reset = 0;
    store(3'd0, 32'h0000_0044, 32'h0000_0099, 0, 0);
    pb(32'h100, 4'b0100, 32'h00DD0000, 0); pr(1, 0);
    drive(3'd0, 32'h102, 32'hAABBCCDD, 0, 0);
`ifdef STORE_SPLIT_EN
    pb(32'h200, 4'b1110, 32'h22334400, 0); pb(32'h204, 4'b0001, 32'h00000011, 0); pr(1, 0);
    drive(3'd2, 32'h201, 32'h11223344, 0, 0);
    pb(32'hFFFFFFFC, 4'b1000, 32'hEF000000, 0); pb(32'h0, 4'b0001, 32'h000000BE, 0); pr(1, 0);
    drive(3'd1, 32'hFFFFFFFF, 32'h0000BEEF, 0, 0);
    pb(32'h200, 4'b1000, 32'h44000000, 0); pb(32'h204, 4'b0111, 32'h00112233, 0); pr(1, 0);
    drive(3'd2, 32'h203, 32'h11223344, 1, 2);
    pb(32'h400, 4'b1100, 32'h33440000, 0); pb(32'h404, 4'b0011, 32'h00001122, 1); pr(0, 1);
    drive(3'd2, 32'h402, 32'h11223344, 0, 9);
`else
    pr(0, 1); drive(3'd2, 32'h201, 32'h11223344, 0, 0);
    pr(0, 1); drive(3'd1, 32'hFFFFFFFF, 32'h0000BEEF, 0, 0);
    pr(0, 1); drive(3'd2, 32'h203, 32'h11223344, 0, 0);
`endif
    pb(32'h200, 4'b1111, 32'h11223344, 0); pr(1, 0);
    drive(3'd2, 32'h200, 32'h11223344, 0, 0);
    pb(32'h300, 4'b1111, 32'hCAFEF00D, 1); pr(0, 1);
    drive(3'd2, 32'h300, 32'hCAFEF00D, 10, 0);
    pr(0, 1); drive(3'd3, 32'h500, 32'h55555555, 0, 0);
    pb(32'h600, 4'b0011, 32'h0000BEEF, 0); pr(1, 0);
    drive(3'd1, 32'h600, 32'hDEADBEEF, 3, 0);
    for (int n = 0; n < 200; n++) begin
      op = ($urandom % 6 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr = ($urandom % 5 == 0) ? (32'hFFFFFFFC | 32'($urandom % 4)) : $urandom;
      w0 = ($urandom % 8 == 0) ? 4 + int'($urandom % 3) : int'($urandom % 3);
      w1 = ($urandom % 8 == 0) ? 4 + int'($urandom % 3) : int'($urandom % 3);
      store(op, addr, $urandom, w0, w1);
    end
    repeat (5) @(posedge Clk);
    #1;
    chk("beats_drained", bq.size(), 0);
    chk("resps_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/data_mem_store_ctrl.md
Name: data_mem_store_ctrl

Overview:
- Sequences every core store into the word-wide data memory.
- Latches one store request and generates the word address, byte-lane enables (Write_Ctrl) and lane-aligned write data.
- Drives the memory write handshake and splits misaligned SH/SW into two aligned beats.
- Sits between the execute-stage store path and the data memory; stalls the core through Store_Ready.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles a beat waits for Mem_Ready before abort; legal range 1-255.
- ADDR_WIDTH, 32: byte-address width.

Ports:
- Clk  input  1  core clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Store_Req  input  1  store request; sampled only when Store_Ready=1.
- Store_Ready  output  1  controller idle and able to accept a request.
- Lw_Sw_OP  input  3  store type: 000 SB, 001 SH, 010 SW; all other codes are invalid.
- Store_Addr  input  ADDR_WIDTH  byte address of the store.
- Register_In_B  input  32  store data; only the low bytes are used for SB/SH.
- Mem_Wr_En  output  1  write beat valid.
- Mem_Ready  input  1  memory accepts the current beat this cycle.
- Mem_Addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] are always 00.
- Write_Ctrl  output  4  byte-lane enables; bit i enables lane i (bits 8i+7:8i).
- Data_Mem_Write  output  32  lane-aligned write data; disabled lanes are 0.
- Store_Done  output  1  one-cycle pulse: store fully committed.
- Store_Err  output  1  one-cycle pulse: invalid op, timeout, or misaligned fault.

Behaviour:
- Reset (any time, including mid-beat) forces state IDLE and clears all latched fields and the timeout counter. Outputs go immediately to: Mem_Wr_En=0, Mem_Addr=0, Write_Ctrl=0, Data_Mem_Write=0, Store_Done=0, Store_Err=0. Store_Ready=1.
- States: IDLE, WR0, WR1, RESP.
- IDLE:
  - Store_Ready=1.
  - On Store_Req=1: latch op, address offset off=Store_Addr[1:0], word address Store_Addr with [1:0] cleared, and rot = Register_In_B rotated left by 8*off.
  - Then go to WR0 if op is valid, else go to RESP with the error flag set.
- Lane mask: base mask is 0001 (SB), 0011 (SH) or 1111 (SW). full = base << off, 8 bits wide.
  - Beat0 enables = full[3:0]; beat1 enables = full[7:4].
  - A store is split iff full[7:4] != 0, i.e. SH with off=3, or SW with off != 0.
- WR0:
  - Mem_Wr_En=1, Mem_Addr=word address, Write_Ctrl=beat0 enables, Data_Mem_Write = rot masked to the enabled lanes.
  - On Mem_Ready: go to WR1 if split, else go to RESP.
- WR1:
  - Mem_Wr_En=1, Mem_Addr = word address + 4 (modulo 2^ADDR_WIDTH, so wrap to 0 is legal), Write_Ctrl=beat1 enables, same rot masked.
  - On Mem_Ready: go to RESP.
- RESP: lasts one cycle. Store_Done=1 on success, Store_Err=1 on failure (never both); then return to IDLE.
- Latency with Mem_Ready tied high:
  - Aligned store: request accepted at cycle 0, beat at cycle 1, Store_Done at cycle 2, Store_Ready at cycle 3.
  - Split store: adds one cycle.
- Beat outputs (Mem_Addr, Write_Ctrl, Data_Mem_Write) are held stable while Mem_Wr_En=1 and Mem_Ready=0.
- Timeout: the counter clears on entry to each beat and increments every cycle Mem_Ready=0.
  - When it reaches TIMEOUT_CYCLES, the beat is abandoned and the controller goes to RESP with an error.
  - A beat0 already accepted is not undone.
- Store_Req while Store_Ready=0 is ignored, not queued; the requester must hold it.
- Mem_Ready while Mem_Wr_En=0 is ignored.
- Mem_Ready in the same cycle as the timeout limit: the acceptance wins.

Optional Feature:
- Macro STORE_SPLIT_EN.
- Defined: misaligned SH/SW are split into two beats as described above.
- Undefined: WR1 is not built. Any store whose full[7:4] != 0 goes from IDLE straight to RESP with Store_Err=1 and no memory beat. Aligned stores behave as with the macro defined.

Test Plan:
- Reset values: assert Reset mid-WR0 with Mem_Ready=0 → outputs are 0 in the same cycle and Store_Ready=1; the next SB proceeds normally.
- SB, Store_Addr=0x102, B=0xAABBCCDD, Mem_Ready=1 → one beat: Mem_Addr=0x100, Write_Ctrl=0100, data=0x00DD0000; Store_Done pulse 2 cycles after accept.
- SW, Store_Addr=0x201, B=0x11223344, macro defined:
  - Beat0: addr 0x200, Write_Ctrl=1110, data 0x22334400.
  - Beat1: addr 0x204, Write_Ctrl=0001, data 0x00000011.
  - Store_Done once.
- SH, Store_Addr=0xFFFFFFFF, B=0x0000BEEF → beat0 addr 0xFFFFFFFC, Write_Ctrl=1000, data 0xEF000000; beat1 addr 0x00000000, Write_Ctrl=0001, data 0x000000BE.
- Mem_Ready held 0 with TIMEOUT_CYCLES=4 → beat outputs stable for 4 cycles, then Store_Err pulse, no Store_Done, back to IDLE. Separately: op=011 → Store_Err and no Mem_Wr_En.
- Macro undefined, SW at 0x203 → Store_Err pulse, Mem_Wr_En never asserted. SW at 0x200 still completes with Write_Ctrl=1111.
